// File: rtl/btn_gesture.sv
// btn_gesture: turns debounced press/release pulses into one-cycle gesture
// pulses (click, double click, long press, optional auto-repeat).
// Optional auto-repeat while held is enabled by defining BTN_GESTURE_REPEAT_EN;
// without it repeat_o is tied low and HELD simply waits for the release.
// Port names carry _i/_o suffixes because "repeat" is a reserved word.
// Timing reference: an input pulse sampled at edge T and an output registered
// at edge T are both "cycle T"; dbl_click_o trails the release by one cycle.
module btn_gesture #(
  parameter int unsigned LONG_CYC   = 5000000,
  parameter int unsigned DBL_CYC    = 2500000,
  parameter int unsigned REPEAT_CYC = 1000000,
  localparam int unsigned MAX_LD    = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC,
  localparam int unsigned MAX_CYC   = (MAX_LD > REPEAT_CYC) ? MAX_LD : REPEAT_CYC,
  localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_down_i,
  input  logic btn_up_i,
  output logic click_o,
  output logic dbl_click_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_HELD
  } state_e;

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_TERM  = CNT_W'(DBL_CYC - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             click_q;
  logic             dbl_pend_q;
  logic             dbl_click_q;
  logic             long_q;
  logic             busy_q;

`ifdef BTN_GESTURE_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REPEAT_CYC - 1);
  logic             rep_q;
`endif

  // Gesture FSM: state, shared counter and every registered output pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, state and outputs alike, returns to a known
    // value on reset so an aborted gesture can never leak a late pulse.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      click_q     <= 1'b0;
      dbl_pend_q  <= 1'b0;
      dbl_click_q <= 1'b0;
      long_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BTN_GESTURE_REPEAT_EN
      rep_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below
      // are overridden later in the same block, giving one-cycle pulses.
      click_q     <= 1'b0;
      long_q      <= 1'b0;
      dbl_pend_q  <= 1'b0;
      dbl_click_q <= dbl_pend_q;
`ifdef BTN_GESTURE_REPEAT_EN
      rep_q       <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (btn_down_i) begin
            state_q <= S_PRESS1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_PRESS1: begin
          // Release beats the long-press timeout on the terminal cycle.
          if (btn_up_i) begin
            state_q <= S_WAIT2;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_TERM) begin
            long_q  <= 1'b1;
            state_q <= S_HELD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT2: begin
          // A second press beats the click timeout on the terminal cycle.
          if (btn_down_i) begin
            state_q <= S_PRESS2;
            cnt_q   <= '0;
          end else if (cnt_q == DBL_TERM) begin
            click_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PRESS2: begin
          if (btn_up_i) begin
            dbl_pend_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
          end
        end
        S_HELD: begin
          if (btn_up_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`ifdef BTN_GESTURE_REPEAT_EN
          end else if (cnt_q == REP_TERM) begin
            rep_q <= 1'b1;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign click_o      = click_q;
  assign dbl_click_o  = dbl_click_q;
  assign long_press_o = long_q;
  assign busy_o       = busy_q;
`ifdef BTN_GESTURE_REPEAT_EN
  assign repeat_o     = rep_q;
`else
  assign repeat_o     = 1'b0;
`endif

endmodule

// File: tb/tb_btn_gesture.sv
// Directed bench for btn_gesture with LONG_CYC=20, DBL_CYC=10, REPEAT_CYC=4.
// Cycle n of a sequence is the n-th rising edge: inputs are set up before it
// and outputs are sampled 1 time unit after it.
module tb_btn_gesture;

  localparam int L = 20;
  localparam int D = 10;
  localparam int R = 4;
`ifdef BTN_GESTURE_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_down = 1'b0;
  logic btn_up = 1'b0;
  logic click, dbl_click, long_press, rep, busy;

  int n_checks = 0;
  int n_fail = 0;

  // Per-run record: index 0 click, 1 dbl_click, 2 long_press, 3 repeat.
  int pcnt [4];
  int pfirst [4];
  int plast [4];
  int multi;
  bit busy_log [0:127];

  btn_gesture #(
    .LONG_CYC  (L),
    .DBL_CYC   (D),
    .REPEAT_CYC(R)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_down_i  (btn_down),
    .btn_up_i    (btn_up),
    .click_o     (click),
    .dbl_click_o (dbl_click),
    .long_press_o(long_press),
    .repeat_o    (rep),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive press pulses at cycles d0/d1 and release pulses at u0/u1 (-1 = none),
  // run len cycles and record every output pulse.
  task automatic run(input int d0, input int d1, input int u0, input int u1,
                     input int len);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) begin
      pcnt[k] = 0; pfirst[k] = -1; plast[k] = -1;
    end
    multi = 0;
    for (int n = 0; n < len; n++) begin
      btn_down = (n == d0) || (n == d1);
      btn_up   = (n == u0) || (n == u1);
      @(posedge clk);
      #1;
      btn_down = 1'b0;
      btn_up   = 1'b0;
      v = {rep, long_press, dbl_click, click};
      if (n < 128) busy_log[n] = busy;
      if ((v[0] + v[1] + v[2] + v[3]) > 1) multi++;
      for (int k = 0; k < 4; k++) begin
        if (v[k]) begin
          pcnt[k]++;
          if (pfirst[k] < 0) pfirst[k] = n;
          plast[k] = n;
        end
      end
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_click", int'(click), 0);
    check("rst_dbl", int'(dbl_click), 0);
    check("rst_long", int'(long_press), 0);
    check("rst_rep", int'(rep), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    run(-1, -1, -1, -1, 3);

    // Reset mid-gesture: press, then 3 cycles of reset, then a release.
    run(0, -1, -1, -1, 5);
    check("mid_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_rst", int'(busy), 0);
    rst_n = 1'b1;
    run(-1, -1, 0, -1, 40);
    check("mid_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
    check("mid_busy_end", int'(busy), 0);

    // Single click: down@0, up@5 -> click@15.
    run(0, -1, 5, -1, 30);
    check("sc_click_n", pcnt[0], 1);
    check("sc_click_at", pfirst[0], 15);
    check("sc_others", pcnt[1] + pcnt[2] + pcnt[3], 0);
    check("sc_busy0", int'(busy_log[0]), 1);
    check("sc_busy14", int'(busy_log[14]), 1);
    check("sc_busy15", int'(busy_log[15]), 0);

    // Double click: down@0 up@3 down@8 up@12 -> dbl@13.
    run(0, 8, 3, 12, 30);
    check("dc_dbl_n", pcnt[1], 1);
    check("dc_dbl_at", pfirst[1], 13);
    check("dc_click_n", pcnt[0], 0);
    check("dc_busy12", int'(busy_log[12]), 0);

    // Second press on the WAIT2 terminal cycle is still a double click.
    run(0, 13, 3, 16, 35);
    check("gap13_dbl_at", pfirst[1], 17);
    check("gap13_click_n", pcnt[0], 0);

    // One cycle later: click@13, then a fresh gesture down@14 up@16 -> click@26.
    run(0, 14, 3, 16, 35);
    check("gap14_click_n", pcnt[0], 2);
    check("gap14_click_1", pfirst[0], 13);
    check("gap14_click_2", plast[0], 26);
    check("gap14_dbl_n", pcnt[1], 0);

    // Long press held to 50.
    run(0, -1, 50, -1, 60);
    check("lp_long_n", pcnt[2], 1);
    check("lp_long_at", pfirst[2], 20);
    check("lp_rep_n", pcnt[3], REP_ON ? 7 : 0);
    check("lp_rep_first", pfirst[3], REP_ON ? 24 : -1);
    check("lp_rep_last", plast[3], REP_ON ? 48 : -1);
    check("lp_click_n", pcnt[0] + pcnt[1], 0);
    check("lp_multi", multi, 0);

    // Release on the repeat terminal cycle suppresses that repeat.
    run(0, -1, 52, -1, 60);
    check("rs_rep_n", pcnt[3], REP_ON ? 7 : 0);
    check("rs_rep_last", plast[3], REP_ON ? 48 : -1);

    // Releases around the long-press terminal cycle.
    run(0, -1, 19, -1, 40);
    check("rt19_long_n", pcnt[2], 0);
    check("rt19_click_at", pfirst[0], 29);
    run(0, -1, 20, -1, 40);
    check("rt20_long_n", pcnt[2], 0);
    check("rt20_click_at", pfirst[0], 30);
    run(0, -1, 21, -1, 40);
    check("rt21_long_at", pfirst[2], 20);
    check("rt21_click_n", pcnt[0], 0);

    // Simultaneous down+up: IDLE takes the press, PRESS1 takes the release.
    run(0, 5, 0, 5, 30);
    check("both_click_at", pfirst[0], 15);
    check("both_click_n", pcnt[0], 1);
    check("both_dbl_n", pcnt[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
